// File: rtl/button_conditioner_pkg.sv
// Shared channel state encoding and default timing for the button conditioner.
// All timing values are in clk cycles (1 ms each at the nominal 1 kHz clock).
package button_conditioner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DEB_P = 3'd1,
      ST_HELD  = 3'd2,
      ST_LONG  = 3'd3,
      ST_DEB_R = 3'd4
   } chan_state_t;

   localparam int DEF_DEB_MS  = 20;
   localparam int DEF_LONG_MS = 1000;
   localparam int DEF_REP_MS  = 200;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM, long-press and auto-repeat timing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | button released and debounced
// ST_DEB_P | synchronized level high, counting toward a debounced press
// ST_HELD  | pressed, counting hold time toward long-press
// ST_LONG  | long-pressed, emitting auto-repeat pulses
// ST_DEB_R | synchronized level low, counting toward a debounced release
module btn_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEB_MS  = DEF_DEB_MS,
   parameter int LONG_MS = DEF_LONG_MS,
   parameter int REP_MS  = DEF_REP_MS
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int CW = $clog2(max3(DEB_MS, LONG_MS, REP_MS) + 1);
   localparam logic [CW-1:0] DEB_TC  = CW'(DEB_MS);
   localparam logic [CW-1:0] LONG_TC = CW'(LONG_MS);
   localparam logic [CW-1:0] REP_TC  = CW'(REP_MS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (DEB_MS < 1 || REP_MS < 1 || LONG_MS <= DEB_MS) begin : g_param_check
      $error("btn_channel: need DEB_MS>=1, REP_MS>=1 and LONG_MS>DEB_MS");
   end

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] tc);
      return (v >= tc) ? v : v + 1'b1;
   endfunction

   logic          sync_meta, s;
   chan_state_t   state, state_nxt;
   logic [CW-1:0] deb_cnt, deb_nxt, hold_cnt, hold_nxt, rep_cnt, rep_nxt;
   logic          long_flag, flag_nxt, level_nxt;
   logic          press_nxt, release_nxt, long_nxt, repeat_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta     <= 1'b0;
         s             <= 1'b0;
         state         <= ST_IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         long_flag     <= 1'b0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         sync_meta     <= btn_raw;
         s             <= sync_meta;
         state         <= state_nxt;
         deb_cnt       <= deb_nxt;
         hold_cnt      <= hold_nxt;
         rep_cnt       <= rep_nxt;
         long_flag     <= flag_nxt;
         btn_level     <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         repeat_pulse  <= repeat_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      deb_nxt     = deb_cnt;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      flag_nxt    = long_flag;
      level_nxt   = btn_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (s) begin
               state_nxt = ST_DEB_P;
               deb_nxt   = CNT_ONE;
            end
         end
         ST_DEB_P: begin
            if (!s) begin
               state_nxt = ST_IDLE;
               deb_nxt   = '0;
            end else begin
               deb_nxt = sat_inc(deb_cnt, DEB_TC);
            end
         end
         ST_HELD: begin
            if (!s) begin
               state_nxt = ST_DEB_R;
               deb_nxt   = CNT_ONE;
               flag_nxt  = 1'b0;
            end else begin
               hold_nxt = sat_inc(hold_cnt, LONG_TC);
            end
         end
         ST_LONG: begin
            if (!s) begin
               state_nxt = ST_DEB_R;
               deb_nxt   = CNT_ONE;
               flag_nxt  = 1'b1;
            end else begin
               rep_nxt = sat_inc(rep_cnt, REP_TC);
            end
         end
         ST_DEB_R: begin
            // A bounce back high resumes timing as if this cycle had been held.
            if (!s) begin
               deb_nxt = sat_inc(deb_cnt, DEB_TC);
            end else if (long_flag) begin
               state_nxt = ST_LONG;
               rep_nxt   = sat_inc(rep_cnt, REP_TC);
            end else begin
               state_nxt = ST_HELD;
               hold_nxt  = sat_inc(hold_cnt, LONG_TC);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Terminal-count resolution shared by every path into a counting state.
      if (state_nxt == ST_DEB_P && deb_nxt == DEB_TC) begin
         state_nxt = ST_HELD;
         press_nxt = 1'b1;
         level_nxt = 1'b1;
         hold_nxt  = '0;
      end
      if (state_nxt == ST_DEB_R && deb_nxt == DEB_TC) begin
         state_nxt   = ST_IDLE;
         release_nxt = 1'b1;
         level_nxt   = 1'b0;
      end
      if (state_nxt == ST_HELD && hold_nxt == LONG_TC) begin
         state_nxt = ST_LONG;
         long_nxt  = 1'b1;
         rep_nxt   = '0;
      end
      if (state_nxt == ST_LONG && rep_nxt == REP_TC) begin
         repeat_nxt = 1'b1;
         rep_nxt    = '0;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button front end: one independent btn_channel per button,
// outputs gathered into per-function buses (bit 0 = mode, bit 1 = start).
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BTN   = 2,
   parameter int DEB_MS  = DEF_DEB_MS,
   parameter int LONG_MS = DEF_LONG_MS,
   parameter int REP_MS  = DEF_REP_MS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse
);

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_channel #(
         .DEB_MS  (DEB_MS),
         .LONG_MS (LONG_MS),
         .REP_MS  (REP_MS)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .btn_raw       (btn_raw[gi]),
         .btn_level     (btn_level[gi]),
         .press_pulse   (press_pulse[gi]),
         .release_pulse (release_pulse[gi]),
         .long_pulse    (long_pulse[gi]),
         .repeat_pulse  (repeat_pulse[gi])
      );
   end

endmodule
